usb_tx_sequencer: RTL and testbench

Parametrised transmit sequencer for the USB side of the encryptor. It pops PID, non-data (token/SOF), payload and data-CRC bytes from their FIFOs and emits them to the bit encoder as SYNC, PID, body, CRC and EOP byte slots. The byte slot length and the maximum payload are configurable. Data payload length is taken per packet from a length input. PID check nibbles are validated and FIFO underflow is detected.

---
 rtl/usb_tx_sequencer_pkg.sv | 39 +++
 rtl/usb_tx_sequencer_byte_slot_timer.sv | 33 +++
 rtl/usb_tx_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_sequencer_pkg.sv
// Shared types for the USB transmit sequencer: FSM state encoding,
// PID classes, the SYNC byte and the PID type decoder.
package usb_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_ND0,
    S_ND1,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP,
    S_DROP
  } tx_state_e;

  typedef enum logic [1:0] {
    PID_TOKEN,
    PID_DATA,
    PID_HAND,
    PID_SPECIAL
  } pid_type_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // PID class is carried in the two low bits of the type nibble
  function automatic pid_type_e pid_type(input logic [7:0] pid);
    pid_type_e t;
    casez (pid)
      8'b??????01: t = PID_TOKEN;
      8'b??????11: t = PID_DATA;
      8'b??????10: t = PID_HAND;
      default:     t = PID_SPECIAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_byte_slot_timer.sv
// Byte slot timer: free-running 0..BYTE_GAP-1 counter marking the first
// and last clock of each byte slot. clear restarts the slot at count 0.
module byte_slot_timer #(
  parameter int BYTE_GAP = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic slot_start,
  output logic slot_end
);

  localparam int CNT_W = $clog2(BYTE_GAP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTE_GAP - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // next count: wrap at the last clock of the slot or on clear
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || (count_q == LAST)) count_d = '0;
  end

  // slot counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign slot_start = (count_q == '0);
  assign slot_end   = (count_q == LAST);

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: emits SYNC, PID, body (token/SOF bytes or data
// payload plus CRC) and EOP byte slots to the bit encoder, popping the
// source FIFOs as each byte completes.
// Optional macro USB_TX_PID_CHECK_EN: reject PIDs whose check nibble is
// not the complement of the type nibble (error pulse, PID dropped).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle (EOP), waiting for tx_start with a PID queued
// S_SYNC   | SYNC byte slot; PID latched at slot start
// S_PID    | PID byte slot; payload length latched/clamped for data
// S_ND0/1  | two token/SOF body bytes from the non-data FIFO
// S_DATA   | payload bytes, payload_len of them
// S_CRC_LO | data CRC low byte
// S_CRC_HI | data CRC high byte
// S_EOP    | one EOP slot; PID popped on its last clock
// S_DROP   | rejected PID is popped, then back to idle
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int BYTE_GAP    = 16,
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic             pid_empty,
  input  logic [7:0]       pid_read,
  input  logic             nd_empty,
  input  logic [7:0]       nd_read,
  input  logic             data_empty,
  input  logic [7:0]       data_read,
  input  logic [7:0]       dcrc_read,
  input  logic [LEN_W-1:0] payload_len,
  output logic [7:0]       write,
  output logic             write_enable,
  output logic             pid_enable,
  output logic             nd_enable,
  output logic             data_enable,
  output logic             dcrc_enable,
  output logic             eop_enable,
  output logic             busy,
  output logic             tx_error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  tx_state_e        state_q, state_d;
  logic [7:0]       pid_q, pid_d;
  logic [7:0]       write_q, write_d;
  logic [7:0]       byte_sel;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             len_over;
  logic             slot_start, slot_end;
  logic             timer_clr;

  byte_slot_timer #(
    .BYTE_GAP (BYTE_GAP)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (timer_clr),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  assign len_over = (payload_len > MAX_LEN);

  // next-state, byte selection and strobes
  always_comb begin
    state_d      = state_q;
    pid_d        = pid_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    byte_sel     = 8'h00;
    write_enable = 1'b0;
    pid_enable   = 1'b0;
    nd_enable    = 1'b0;
    data_enable  = 1'b0;
    dcrc_enable  = 1'b0;
    eop_enable   = 1'b0;
    busy         = 1'b1;
    tx_error     = 1'b0;
    timer_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        eop_enable = 1'b1;
        busy       = 1'b0;
        timer_clr  = 1'b1;
        if (tx_start && !pid_empty) state_d = S_SYNC;
      end

      S_SYNC: begin
        if (slot_start) begin
          // Back-to-back entry decides on the pre-pop flag; the post-pop
          // flag is checked here so an emptied FIFO aborts cleanly.
          if (pid_empty) begin
            state_d   = S_IDLE;
            timer_clr = 1'b1;
          end
`ifdef USB_TX_PID_CHECK_EN
          else if (pid_read[7:4] != ~pid_read[3:0]) begin
            tx_error  = 1'b1;
            state_d   = S_DROP;
            timer_clr = 1'b1;
          end
`endif
          else begin
            write_enable = 1'b1;
            byte_sel     = SYNC_BYTE;
            pid_d        = pid_read;
          end
        end else if (slot_end) begin
          state_d = S_PID;
        end
      end

      S_PID: begin
        if (slot_start) begin
          write_enable = 1'b1;
          byte_sel     = pid_q;
          cnt_d        = '0;
          if (pid_type(pid_q) == PID_DATA) begin
            len_d    = len_over ? MAX_LEN : payload_len;
            tx_error = len_over;
          end
        end else if (slot_end) begin
          case (pid_type(pid_q))
            PID_DATA: state_d = (len_q == '0) ? S_CRC_LO : S_DATA;
            PID_HAND: state_d = S_EOP;
            default:  state_d = S_ND0;
          endcase
        end
      end

      S_ND0, S_ND1: begin
        if (slot_start) begin
          if (nd_empty) begin
            tx_error  = 1'b1;
            state_d   = S_EOP;
            timer_clr = 1'b1;
          end else begin
            write_enable = 1'b1;
            byte_sel     = nd_read;
          end
        end else if (slot_end) begin
          nd_enable = 1'b1;
          state_d   = (state_q == S_ND0) ? S_ND1 : S_EOP;
        end
      end

      S_DATA: begin
        if (slot_start) begin
          if (data_empty) begin
            tx_error  = 1'b1;
            state_d   = S_EOP;
            timer_clr = 1'b1;
          end else begin
            write_enable = 1'b1;
            byte_sel     = data_read;
          end
        end else if (slot_end) begin
          data_enable = 1'b1;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = S_CRC_LO;
        end
      end

      S_CRC_LO, S_CRC_HI: begin
        if (slot_start) begin
          write_enable = 1'b1;
          byte_sel     = dcrc_read;
        end else if (slot_end) begin
          dcrc_enable = 1'b1;
          state_d     = (state_q == S_CRC_LO) ? S_CRC_HI : S_EOP;
        end
      end

      S_EOP: begin
        eop_enable = 1'b1;
        if (slot_end) begin
          pid_enable = 1'b1;
          state_d    = (tx_start && !pid_empty) ? S_SYNC : S_IDLE;
        end
      end

      S_DROP: begin
        eop_enable = 1'b1;
        busy       = 1'b0;
        pid_enable = 1'b1;
        timer_clr  = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        timer_clr = 1'b1;
      end
    endcase
  end

  // the encoder byte is held between loads so it stays stable mid-slot
  always_comb begin
    write_d = write_enable ? byte_sel : write_q;
    write   = write_d;
  end

  // state, latched PID, length and byte counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= 8'h00;
      len_q   <= '0;
      cnt_q   <= '0;
      write_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic       pid_empty, nd_empty, data_empty;
  logic [7:0] pid_read, nd_read, data_read, dcrc_read;
  logic [6:0] payload_len;
  logic [7:0] write;
  logic       write_enable, pid_enable, nd_enable, data_enable, dcrc_enable;
  logic       eop_enable, busy, tx_error;

  int checks = 0;
  int failures = 0;

  logic [7:0] pidq[$], ndq[$], dq[$], cq[$];
  logic [7:0] wr_log[$];
  int         wr_cyc[$], pid_cycs[$], err_cycs[$];
  int         n_nd, n_data, n_dcrc;
  bit         eop_at[256];
  bit         busy_at[256];
  int         cyc;
  bit         pp, pn, pd, pc;
  logic [7:0] tmp;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .pid_empty    (pid_empty),
    .pid_read     (pid_read),
    .nd_empty     (nd_empty),
    .nd_read      (nd_read),
    .data_empty   (data_empty),
    .data_read    (data_read),
    .dcrc_read    (dcrc_read),
    .payload_len  (payload_len),
    .write        (write),
    .write_enable (write_enable),
    .pid_enable   (pid_enable),
    .nd_enable    (nd_enable),
    .data_enable  (data_enable),
    .dcrc_enable  (dcrc_enable),
    .eop_enable   (eop_enable),
    .busy         (busy),
    .tx_error     (tx_error)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic logic [63:0] pack_log();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) v[63-8*i -: 8] = wr_log[i];
    return v;
  endfunction

  task automatic refresh();
    pid_empty  = (pidq.size() == 0);
    pid_read   = pid_empty ? 8'h00 : pidq[0];
    nd_empty   = (ndq.size() == 0);
    nd_read    = nd_empty ? 8'h00 : ndq[0];
    data_empty = (dq.size() == 0);
    data_read  = data_empty ? 8'h00 : dq[0];
    dcrc_read  = (cq.size() == 0) ? 8'h00 : cq[0];
  endtask

  task automatic sample();
    @(negedge clk);
    if (write_enable) begin
      wr_log.push_back(write);
      wr_cyc.push_back(cyc);
    end
    if (pid_enable) pid_cycs.push_back(cyc);
    if (tx_error) err_cycs.push_back(cyc);
    if (nd_enable) n_nd++;
    if (data_enable) n_data++;
    if (dcrc_enable) n_dcrc++;
    if (cyc < 256) begin
      eop_at[cyc]  = eop_enable;
      busy_at[cyc] = busy;
    end
    pp = pid_enable; pn = nd_enable; pd = data_enable; pc = dcrc_enable;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pp && pidq.size() > 0) tmp = pidq.pop_front();
    if (pn && ndq.size() > 0) tmp = ndq.pop_front();
    if (pd && dq.size() > 0) tmp = dq.pop_front();
    if (pc && cq.size() > 0) tmp = cq.pop_front();
    pp = 0; pn = 0; pd = 0; pc = 0;
    refresh();
    cyc++;
    sample();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tx_start = 1'b0;
    payload_len = '0;
    pidq.delete(); ndq.delete(); dq.delete(); cq.delete();
    pp = 0; pn = 0; pd = 0; pc = 0;
    refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic begin_pkt();
    @(posedge clk);
    #1;
    refresh();
    tx_start = 1'b1;
    wr_log.delete(); wr_cyc.delete(); pid_cycs.delete(); err_cycs.delete();
    n_nd = 0; n_data = 0; n_dcrc = 0;
    for (int i = 0; i < 256; i++) begin
      eop_at[i] = 0;
      busy_at[i] = 0;
    end
    cyc = 0;
    sample();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({write, write_enable, pid_enable, nd_enable, data_enable, dcrc_enable, eop_enable, busy, tx_error}
        !== {8'h00, 5'b0, 1'b1, 2'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got write=%h we=%b pe=%b ne=%b de=%b ce=%b eop=%b busy=%b err=%b want 00/0/0/0/0/0/1/0/0",
               write, write_enable, pid_enable, nd_enable, data_enable, dcrc_enable, eop_enable, busy, tx_error);
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    pidq = {8'hC3}; dq = {8'h11, 8'h22, 8'h33}; cq = {8'hAB, 8'hCD};
    payload_len = 7'd3;
    begin_pkt();
    run_to(40);
    checks++;
    if (wr_log.size() != 3) begin
      failures++;
      $display("FAIL mid_data_pre_bytes: got %0d bytes want 3", wr_log.size());
    end
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    tx_start = 1'b0;
    #1;
    checks++;
    if ({write, write_enable, pid_enable, nd_enable, data_enable, dcrc_enable, eop_enable, busy, tx_error}
        !== {8'h00, 5'b0, 1'b1, 2'b0}) begin
      failures++;
      $display("FAIL mid_data_reset_outputs: got write=%h we=%b eop=%b busy=%b err=%b want 00/0/1/0/0",
               write, write_enable, eop_enable, busy, tx_error);
    end
    repeat (20) step();
    checks++;
    if ({pidq.size(), dq.size(), cq.size(), n_data, pid_cycs.size()} !== {32'd1, 32'd3, 32'd2, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL mid_data_no_pops: got pid=%0d data=%0d crc=%0d dpops=%0d ppops=%0d want 1/3/2/0/0",
               pidq.size(), dq.size(), cq.size(), n_data, pid_cycs.size());
    end
  endtask

  task automatic test_handshake();
    do_reset();
    pidq = {8'hD2};
    begin_pkt();
    run_to(60);
    checks++;
    if (wr_log.size() != 2 || pack_log() !== 64'h80D2_0000_0000_0000) begin
      failures++;
      $display("FAIL hand_bytes: got n=%0d %h want n=2 80D2", wr_log.size(), pack_log());
    end
    checks++;
    if (at(wr_cyc, 0) != 1 || at(wr_cyc, 1) != 17) begin
      failures++;
      $display("FAIL hand_we_cycles: got %0d,%0d want 1,17", at(wr_cyc, 0), at(wr_cyc, 1));
    end
    checks++;
    if ({eop_at[32], eop_at[33], eop_at[40], eop_at[48]} !== 4'b0111) begin
      failures++;
      $display("FAIL hand_eop_window: got c32..48=%b%b%b%b want 0111",
               eop_at[32], eop_at[33], eop_at[40], eop_at[48]);
    end
    checks++;
    if (pid_cycs.size() != 1 || at(pid_cycs, 0) != 48) begin
      failures++;
      $display("FAIL hand_pid_pop: got n=%0d cyc=%0d want n=1 cyc=48", pid_cycs.size(), at(pid_cycs, 0));
    end
    checks++;
    if (busy_at[48] !== 1'b1 || busy_at[55] !== 1'b0 || err_cycs.size() != 0) begin
      failures++;
      $display("FAIL hand_busy_end: got busy48=%b busy55=%b errs=%0d want 1/0/0",
               busy_at[48], busy_at[55], err_cycs.size());
    end
  endtask

  task automatic test_token();
    do_reset();
    pidq = {8'h69}; ndq = {8'h15, 8'hA3};
    begin_pkt();
    run_to(100);
    checks++;
    if (wr_log.size() != 4 || pack_log() !== 64'h8069_15A3_0000_0000) begin
      failures++;
      $display("FAIL token_bytes: got n=%0d %h want n=4 806915A3", wr_log.size(), pack_log());
    end
    checks++;
    if (n_nd != 2 || pid_cycs.size() != 1 || at(pid_cycs, 0) != 80 || err_cycs.size() != 0) begin
      failures++;
      $display("FAIL token_pops: got nd=%0d pid=%0d@%0d errs=%0d want 2/1@80/0",
               n_nd, pid_cycs.size(), at(pid_cycs, 0), err_cycs.size());
    end
  endtask

  task automatic test_data();
    do_reset();
    pidq = {8'hC3}; dq = {8'h11, 8'h22, 8'h33}; cq = {8'hAB, 8'hCD};
    payload_len = 7'd3;
    begin_pkt();
    run_to(140);
    checks++;
    if (wr_log.size() != 7 || pack_log() !== 64'h80C3_1122_33AB_CD00) begin
      failures++;
      $display("FAIL data_bytes: got n=%0d %h want n=7 80C3112233ABCD", wr_log.size(), pack_log());
    end
    checks++;
    if (n_data != 3 || n_dcrc != 2 || at(pid_cycs, 0) != 128 || at(wr_cyc, 6) != 97) begin
      failures++;
      $display("FAIL data_pops: got data=%0d crc=%0d pid@%0d crchi@%0d want 3/2/128/97",
               n_data, n_dcrc, at(pid_cycs, 0), at(wr_cyc, 6));
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    pidq = {8'hC3}; cq = {8'hAB, 8'hCD};
    payload_len = 7'd0;
    begin_pkt();
    run_to(90);
    checks++;
    if (wr_log.size() != 4 || pack_log() !== 64'h80C3_ABCD_0000_0000 || at(wr_cyc, 2) != 33) begin
      failures++;
      $display("FAIL zlp_bytes: got n=%0d %h crclo@%0d want n=4 80C3ABCD @33",
               wr_log.size(), pack_log(), at(wr_cyc, 2));
    end
    checks++;
    if (n_data != 0 || n_dcrc != 2 || at(pid_cycs, 0) != 80) begin
      failures++;
      $display("FAIL zlp_pops: got data=%0d crc=%0d pid@%0d want 0/2/80", n_data, n_dcrc, at(pid_cycs, 0));
    end
  endtask

  task automatic test_data_underflow();
    do_reset();
    pidq = {8'hC3}; dq = {8'h11}; cq = {8'hAB, 8'hCD};
    payload_len = 7'd2;
    begin_pkt();
    run_to(90);
    checks++;
    if (wr_log.size() != 3 || pack_log() !== 64'h80C3_1100_0000_0000) begin
      failures++;
      $display("FAIL dunder_bytes: got n=%0d %h want n=3 80C311", wr_log.size(), pack_log());
    end
    checks++;
    if (err_cycs.size() != 1 || at(err_cycs, 0) != 49) begin
      failures++;
      $display("FAIL dunder_error: got n=%0d @%0d want 1 @49", err_cycs.size(), at(err_cycs, 0));
    end
    checks++;
    if (n_data != 1 || n_dcrc != 0 || at(pid_cycs, 0) != 65 || eop_at[50] !== 1'b1) begin
      failures++;
      $display("FAIL dunder_pops: got data=%0d crc=%0d pid@%0d eop50=%b want 1/0/65/1",
               n_data, n_dcrc, at(pid_cycs, 0), eop_at[50]);
    end
  endtask

  task automatic test_nd_underflow();
    do_reset();
    pidq = {8'h69}; ndq = {8'h15};
    begin_pkt();
    run_to(90);
    checks++;
    if (wr_log.size() != 3 || at(err_cycs, 0) != 49 || n_nd != 1 || at(pid_cycs, 0) != 65) begin
      failures++;
      $display("FAIL ndunder: got bytes=%0d err@%0d nd=%0d pid@%0d want 3/49/1/65",
               wr_log.size(), at(err_cycs, 0), n_nd, at(pid_cycs, 0));
    end
  endtask

  task automatic test_clamp();
    do_reset();
    pidq = {8'hC3}; dq = {8'h11};
    payload_len = 7'd100;
    begin_pkt();
    run_to(20);
    checks++;
    if (err_cycs.size() != 1 || at(err_cycs, 0) != 17) begin
      failures++;
      $display("FAIL clamp_error: got n=%0d @%0d want 1 @17", err_cycs.size(), at(err_cycs, 0));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pidq = {8'hD2, 8'h5A};
    begin_pkt();
    run_to(110);
    checks++;
    if (wr_log.size() != 4 || pack_log() !== 64'h80D2_805A_0000_0000) begin
      failures++;
      $display("FAIL b2b_bytes: got n=%0d %h want n=4 80D2805A", wr_log.size(), pack_log());
    end
    checks++;
    if (at(pid_cycs, 0) != 48 || at(wr_cyc, 2) != 49 || at(wr_cyc, 3) != 65 || at(pid_cycs, 1) != 96) begin
      failures++;
      $display("FAIL b2b_timing: got pid0@%0d sync2@%0d pid2@%0d pid1@%0d want 48/49/65/96",
               at(pid_cycs, 0), at(wr_cyc, 2), at(wr_cyc, 3), at(pid_cycs, 1));
    end
  endtask

  task automatic test_pid_check();
    do_reset();
    pidq = {8'hC4}; ndq = {8'h15, 8'hA3};
    begin_pkt();
    run_to(20);
`ifdef USB_TX_PID_CHECK_EN
    checks++;
    if (at(err_cycs, 0) != 1 || at(pid_cycs, 0) != 2 || wr_log.size() != 0 || pidq.size() != 0) begin
      failures++;
      $display("FAIL pidchk_reject: got err@%0d pid@%0d bytes=%0d left=%0d want 1/2/0/0",
               at(err_cycs, 0), at(pid_cycs, 0), wr_log.size(), pidq.size());
    end
`else
    checks++;
    if (pack_log() !== 64'h80C4_0000_0000_0000 || err_cycs.size() != 0) begin
      failures++;
      $display("FAIL pidchk_passthru: got %h errs=%0d want 80C4 0", pack_log(), err_cycs.size());
    end
`endif
  endtask

  initial begin
    n_rst = 1'b0;
    tx_start = 1'b0;
    payload_len = '0;
    refresh();
    test_reset();
    test_reset_mid_data();
    test_handshake();
    test_token();
    test_data();
    test_zero_len();
    test_data_underflow();
    test_nd_underflow();
    test_clamp();
    test_back_to_back();
    test_pid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
